chart_loader: RTL

CHART_LOADER -- requirements
Module: chart_loader

---
 rtl/chart_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/chart_loader.sv
// chart_loader
// Accepts a stream of chart entries over a valid/ready handshake and writes
// them into consecutive chart RAM addresses starting at 0. A start pulse
// begins (or restarts) a load. The load finishes when the entry marked last
// arrives or when the RAM is full. Filling the RAM without a last entry sets
// the sticky overflow flag.
//
// Ports
//   clk_i       : clock, all state updates on the rising edge
//   reset_i     : asynchronous active-high reset
//   start_i     : one-cycle pulse, begin/restart a load at address 0
//   valid_i     : upstream entry valid
//   data_i      : chart entry {arrows[3:0], timing[3:0]}
//   last_i      : final entry of the chart (qualified by valid_i)
//   ready_o     : entry accepted this cycle when valid_i is also high
//   wr_valid_o  : chart RAM write strobe (one cycle per accepted entry)
//   wr_addr_o   : chart RAM write address
//   wr_data_o   : chart RAM write data
//   busy_o      : load in progress
//   done_o      : load finished
//   length_o    : entries written by the current or most recent load
//   overflow_o  : RAM filled without a last entry
module chart_loader #(
  parameter int WIDTH_P      = 8,
  parameter int ADDR_WIDTH_P = 7
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    valid_i,
  input  logic [WIDTH_P-1:0]      data_i,
  input  logic                    last_i,
  output logic                    ready_o,
  output logic                    wr_valid_o,
  output logic [ADDR_WIDTH_P-1:0] wr_addr_o,
  output logic [WIDTH_P-1:0]      wr_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDR_WIDTH_P:0]   length_o,
  output logic                    overflow_o
);

  localparam logic [ADDR_WIDTH_P-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH_P:0]   LEN_ONE   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH_P:0]   length_reg;
  logic                    overflow_reg;
  logic                    wr_valid_reg;
  logic [ADDR_WIDTH_P-1:0] wr_addr_reg;
  logic [WIDTH_P-1:0]      wr_data_reg;

  logic [ADDR_WIDTH_P-1:0] ptr;
  logic                    accept;
  logic                    at_end;

  // The write pointer always equals the entry count during a load; the
  // extra MSB of the count only becomes set once the load has left LOAD,
  // so the pointer never wraps back to address 0 while accepting.
  assign ptr    = length_reg[ADDR_WIDTH_P-1:0];
  assign at_end = (ptr == LAST_ADDR);
  assign accept = valid_i & ready_o;

  always_comb begin
    // A start pulse takes priority over any beat presented in the same cycle.
    ready_o    = (state_reg == LOAD) && !start_i;
    state_next = state_reg;
    if (start_i) begin
      state_next = LOAD;
    end else if (accept && (last_i || at_end)) begin
      state_next = DONE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      length_reg   <= '0;
      overflow_reg <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      wr_valid_reg <= accept;
      if (start_i) begin
        length_reg   <= '0;
        overflow_reg <= 1'b0;
      end else if (accept) begin
        wr_addr_reg <= ptr;
        wr_data_reg <= data_i;
        length_reg  <= length_reg + LEN_ONE;
        if (at_end && !last_i) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  assign wr_valid_o = wr_valid_reg;
  assign wr_addr_o  = wr_addr_reg;
  assign wr_data_o  = wr_data_reg;
  assign busy_o     = (state_reg == LOAD);
  assign done_o     = (state_reg == DONE);
  assign length_o   = length_reg;
  assign overflow_o = overflow_reg;

endmodule
